// File: rtl/mem_if_pkg.sv
// Shared constants and state encoding for the memory responder and its word store.
package mem_if_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_ACK  = ST_ACK
    } state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W word store: synchronous write, registered read, no reset.
module mem_array #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              we_c,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_c) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a tagged request, waits WAIT_STATES cycles,
// accesses the word store and returns a one-cycle acknowledge.
//
// state  | meaning
// IDLE   | ready; req accepted here (this is also the cycle ack is visible)
// WAIT   | counting wait states, busy = 1, req ignored
// ACK    | array access; the edge leaving it commits and raises ack for one cycle
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = mem_if_pkg::ADDR_W,
    parameter int DATA_W      = mem_if_pkg::DATA_W,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] admem,
    input  logic              req,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              fetch,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              rsp_fetch,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fetch_q, fetch_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              rsp_fetch_q, rsp_fetch_d;
    logic              busy_q, busy_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        fetch_d     = fetch_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        rsp_fetch_d = rsp_fetch_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = admem;
                    we_d    = we;
                    wdata_d = wdata;
                    fetch_d = fetch;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                state_d     = S_IDLE;
                ack_d       = 1'b1;
                rsp_fetch_d = fetch_q;
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            fetch_q     <= 1'b0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            rsp_fetch_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            fetch_q     <= fetch_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            rsp_fetch_q <= rsp_fetch_d;
            busy_q      <= busy_d;
        end
    end

    // Read port is addressed by the next request address so the word is already
    // registered when ACK is entered, even with zero wait states.
    assign mem_we = (state_q == S_ACK) && we_q;

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we_c  (mem_we),
        .addr  (addr_d),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign rsp_fetch = rsp_fetch_q;
    assign busy      = busy_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's fetch/data address path. It completes the memory end of the interface that the address multiplexer drives.
- It accepts a registered 5-bit memory address with a request qualifier. It then performs a read or write on a 32x32-bit word store after a fixed number of wait states.
- It returns the result with a one-cycle acknowledge. The response is tagged as an instruction fetch or a data access, so the core can steer the word to the IR or to the datapath.

Parameters:
- ADDR_W, 5, address width; it matches the admem bus.
- DATA_W, 32, word width.
- DEPTH, 32, number of words; must equal 2**ADDR_W.
- WAIT_STATES, 2, number of idle cycles between accept and acknowledge; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- admem  input  ADDR_W  word address from the address multiplexer.
- req  input  1  transaction request, sampled on the rising edge.
- we  input  1  1 = write, 0 = read; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- fetch  input  1  access tag: 1 = instruction fetch, 0 = data access; sampled with req.
- rdata  output  DATA_W  read data; valid while ack = 1.
- ack  output  1  one-cycle completion strobe.
- rsp_fetch  output  1  echo of the fetch tag of the completing transaction; valid while ack = 1.
- busy  output  1  high while a transaction is in WAIT state.

Behaviour:
- Reset: on rst_n low, immediately (asynchronously) force the following, and hold them while rst_n is low:
  - state = IDLE, wait counter = 0;
  - ack = 0, busy = 0, rsp_fetch = 0, rdata = 0.
  - The storage array is not reset; its contents are undefined until written.
- States are IDLE, WAIT and ACK. busy = (state == WAIT). ack = (state == ACK).
- Accept:
  - req = 1 is accepted only in IDLE or ACK.
  - On the accepting edge, latch admem, we, wdata and fetch into request registers.
  - Next state is WAIT with counter = WAIT_STATES-1, or ACK directly if WAIT_STATES = 0.
- WAIT: the counter decrements each edge. When the counter is 0, the next edge goes to ACK.
- Commit happens on the edge that enters ACK:
  - Read: rdata <= mem[latched addr].
  - Write: mem[latched addr] <= latched wdata; rdata holds its previous value.
  - rsp_fetch <= latched fetch.
- Latency: if a request is accepted at edge N, ack is high for exactly the cycle following edge N+1+WAIT_STATES.
- ACK lasts exactly one cycle:
  - If req = 1 in the ACK cycle, it is accepted (back-to-back). One transaction completes every WAIT_STATES+2 cycles.
  - Otherwise the next state is IDLE.
- req during WAIT is ignored entirely. It is not queued, and admem/we/wdata/fetch are not sampled.
- rdata and rsp_fetch hold their values after ack falls, until the next commit.
- Address range: all 2**ADDR_W addresses are valid. Address 31 and address 0 are distinct words, with no wrap or aliasing.
- Reset mid-operation:
  - A transaction in WAIT is dropped, with no ack.
  - A write not yet committed does not modify the array.
  - After rst_n rises, the first accepting edge behaves as from IDLE.
- Read-after-write to the same address, back-to-back: the read commits after the write edge, so it returns the new data.

Decomposition:
- Shared package mem_if_pkg contains:
  - ADDR_W and DATA_W constants;
  - state encoding localparams ST_IDLE, ST_WAIT, ST_ACK (2-bit);
  - the WAIT_STATES counter width (4).
- One natural sub-module, mem_array: a DEPTH x DATA_W store with a synchronous write port and a synchronous read port (clk, we_c, addr, wdata, rdata). It has no reset and is instantiated once.
- mem_responder holds the FSM, the counter, the request registers and the ack/tag outputs.

Test Plan (WAIT_STATES = 2 unless noted):
- Reset: hold rst_n = 0 with req = 1 toggling -> ack = 0, busy = 0, rdata = 0x00000000, rsp_fetch = 0 throughout; release -> still IDLE.
- Write then read: req = 1, we = 1, admem = 5, wdata = 0xDEADBEEF, fetch = 0 accepted at edge N -> busy = 1 for 2 cycles, ack = 1 after edge N+3, rdata unchanged. Then read admem = 5 with fetch = 1 -> ack after accept+3, rdata = 0xDEADBEEF, rsp_fetch = 1.
- Back-to-back: req held at 1 with reads of addr 0, 31, 0 (pre-written 0x11111111 and 0x3F3F3F3F) -> ack pulses at edges N+3, N+7 and N+11, returning 0x11111111, 0x3F3F3F3F, 0x11111111.
- Ignored request: during WAIT, drive req = 1, we = 1, admem = 9, wdata = 0xCAFEF00D -> exactly one ack (for the original), and a later read of addr 9 returns its prior value.
- Reset mid-write: write 0x12345678 to addr 7 (holding 0x0BADF00D) and pull rst_n low in the first WAIT cycle -> no ack; after release, a read of addr 7 returns 0x0BADF00D.
- WAIT_STATES = 0 build: read accepted at edge N -> ack after edge N+1, busy never asserted; req held at 1 gives an ack every 2 cycles.
